// File: rtl/cross_correlation_valid.sv
// cross_correlation_valid: buffers sequences A and B, then emits each valid-mode lag sum from one shared MAC
module cross_correlation_valid #(
  parameter int M = 3,
  parameter int N = 3,
  parameter int DATA_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           valid_in_A,
  input  logic                           valid_in_B,
  input  logic signed [DATA_WIDTH-1:0]   a_in,
  input  logic signed [DATA_WIDTH-1:0]   b_in,
  output logic                           valid_out,
  output logic signed [2*DATA_WIDTH-1:0] correlation_out
);
  localparam int AW = $clog2(M + 1);
  localparam int NW = $clog2(N + 1);
  localparam int W = DATA_WIDTH;
  typedef enum logic [1:0] {LOAD, COMPUTE, EMIT} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] a_cnt_q, a_cnt_d, k_q, k_d;
  logic [NW-1:0] b_cnt_q, b_cnt_d, i_q, i_d;
  logic signed [2*W-1:0] acc_q, acc_d, corr_q, corr_d, prod;
  logic valid_q, valid_d;
  logic signed [W-1:0] a_q [2**AW];
  logic signed [W-1:0] a_d [2**AW];
  logic signed [W-1:0] b_q [2**NW];
  logic signed [W-1:0] b_d [2**NW];
  assign prod = a_q[k_q + AW'(i_q)] * b_q[i_q];
  always_comb begin
    state_d = state_q;
    a_cnt_d = a_cnt_q;
    b_cnt_d = b_cnt_q;
    k_d = k_q;
    i_d = i_q;
    acc_d = acc_q;
    corr_d = corr_q;
    valid_d = 1'b0;
    a_d = a_q;
    b_d = b_q;
    case (state_q)
      LOAD: begin
        if (valid_in_A && a_cnt_q != AW'(M)) begin
          a_d[a_cnt_q] = a_in;
          a_cnt_d = a_cnt_q + 1'b1;
        end
        if (valid_in_B && b_cnt_q != NW'(N)) begin
          b_d[b_cnt_q] = b_in;
          b_cnt_d = b_cnt_q + 1'b1;
        end
        if (a_cnt_d == AW'(M) && b_cnt_d == NW'(N)) begin
          state_d = COMPUTE;
          k_d = '0;
          i_d = '0;
          acc_d = '0;
        end
      end
      COMPUTE: begin
        acc_d = acc_q + prod;
        i_d = i_q + 1'b1;
        state_d = i_q == NW'(N - 1) ? EMIT : COMPUTE;
      end
      EMIT: begin
        valid_d = 1'b1;
        corr_d = acc_q;
        if (k_q != AW'(M - N)) begin
          k_d = k_q + 1'b1;
          i_d = '0;
          acc_d = '0;
          state_d = COMPUTE;
        end else begin
          a_cnt_d = '0;
          b_cnt_d = '0;
          k_d = '0;
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= LOAD;
      a_cnt_q <= '0;
      b_cnt_q <= '0;
      k_q <= '0;
      i_q <= '0;
      acc_q <= '0;
      corr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
      k_q <= k_d;
      i_q <= i_d;
      acc_q <= acc_d;
      corr_q <= corr_d;
      valid_q <= valid_d;
      a_q <= a_d;
      b_q <= b_d;
    end
  end
  assign valid_out = valid_q;
  assign correlation_out = corr_q;
endmodule

// File: tb/tb_cross_correlation_valid.sv
// tb_cross_correlation_valid: scoreboard bench for M=N=3 and M=5,N=3 correlators against an arithmetic model
module tb_cross_correlation_valid;
  logic clk = 0;
  logic reset = 0;
  logic [1:0] va, vb, vout;
  logic [1:0][15:0] ain, bin;
  logic [1:0][31:0] cout;
  cross_correlation_valid #(.M(3), .N(3), .DATA_WIDTH(16)) u3 (
    .clk(clk), .reset(reset), .valid_in_A(va[0]), .valid_in_B(vb[0]),
    .a_in(ain[0]), .b_in(bin[0]), .valid_out(vout[0]), .correlation_out(cout[0]));
  cross_correlation_valid #(.M(5), .N(3), .DATA_WIDTH(16)) u5 (
    .clk(clk), .reset(reset), .valid_in_A(va[1]), .valid_in_B(vb[1]),
    .a_in(ain[1]), .b_in(bin[1]), .valid_out(vout[1]), .correlation_out(cout[1]));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int total = 0, bad = 0;
  typedef struct {logic [31:0] v; int c;} exp_t;
  exp_t q0[$], q1[$];
  logic signed [15:0] sa [5];
  logic signed [15:0] sb [3];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask
  function automatic logic [31:0] model(input int k);
    longint s = 0;
    for (int i = 0; i < 3; i++) s += longint'(sa[i + k]) * longint'(sb[i]);
    return s[31:0];
  endfunction
  function automatic int qsize(input int d);
    return d != 0 ? q1.size() : q0.size();
  endfunction
  task automatic mon(input int d);
    exp_t e;
    if (!vout[d]) return;
    if (qsize(d) == 0) begin
      total++;
      bad++;
      $display("FAIL strobe%0d: unexpected valid_out at cycle %0d value %0h want none", d, cyc, cout[d]);
      return;
    end
    e = d != 0 ? q1.pop_front() : q0.pop_front();
    chk($sformatf("value%0d", d), cout[d], e.v);
    chk($sformatf("cycle%0d", d), cyc, e.c);
  endtask
  always @(negedge clk) if (reset) begin
    mon(0);
    mon(1);
  end
  task automatic set3(input int a0, a1, a2, b0, b1, b2);
    sa[0] = 16'(a0); sa[1] = 16'(a1); sa[2] = 16'(a2);
    sb[0] = 16'(b0); sb[1] = 16'(b1); sb[2] = 16'(b2);
  endtask
  // mode: 0 simultaneous, 1 A first (A held high after), 2 B first, 3 random interleave
  task automatic run_pair(input int d, input int mode, input bit garbage);
    int md, na, nb, last;
    bit pa, pb;
    exp_t e;
    md = d != 0 ? 5 : 3;
    na = 0;
    nb = 0;
    last = 0;
    while (na < md || nb < 3) begin
      @(negedge clk);
      case (mode)
        0: begin pa = na < md; pb = nb < 3; end
        1: begin pa = 1; pb = na >= md; end
        2: begin pb = 1; pa = nb >= 3; end
        default: begin pa = 1'($urandom); pb = 1'($urandom); end
      endcase
      va[d] = pa;
      vb[d] = pb;
      if (na < md) ain[d] = sa[na];
      else ain[d] = mode == 1 ? 16'd0 : 16'($urandom);
      if (nb < 3) bin[d] = sb[nb];
      else bin[d] = 16'($urandom);
      if (pa && na < md) na++;
      if (pb && nb < 3) nb++;
    end
    for (int k = 0; k <= md - 3; k++) begin
      e.v = model(k);
      e.c = cyc + 1 + 4 * (k + 1);
      last = e.c;
      if (d != 0) q1.push_back(e);
      else q0.push_back(e);
    end
    @(negedge clk);
    while (garbage && cyc < last) begin
      va[d] = 1'($urandom);
      vb[d] = 1'($urandom);
      ain[d] = 16'($urandom);
      bin[d] = 16'($urandom);
      @(negedge clk);
    end
    va[d] = 0;
    vb[d] = 0;
    for (int t = 0; t < 100 && qsize(d) > 0; t++) @(negedge clk);
    if (qsize(d) > 0) begin
      total++;
      bad++;
      $display("FAIL timeout%0d: %0d results outstanding want 0", d, qsize(d));
      if (d != 0) q1.delete();
      else q0.delete();
    end
  endtask
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    va = 0; vb = 0; ain = '0; bin = '0;
    repeat (3) @(negedge clk);
    reset = 1;
    chk("rst_valid3", 32'(vout[0]), 0);
    chk("rst_corr3", cout[0], 0);
    chk("rst_valid5", 32'(vout[1]), 0);
    chk("rst_corr5", cout[1], 0);
    set3(1, 2, 3, 1, 2, 4);
    run_pair(0, 1, 0);
    set3(-1, -2, -3, 1, 2, 4);
    run_pair(0, 2, 0);
    set3(-32768, -32768, -32768, -32768, -32768, -32768);
    run_pair(0, 0, 0);
    set3(5, 6, 7, 8, 9, 10);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      va[0] = 1; vb[0] = 1; ain[0] = sa[i]; bin[0] = sb[i];
    end
    @(negedge clk);
    va[0] = 0; vb[0] = 0;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    reset = 1;
    chk("midrst_valid", 32'(vout[0]), 0);
    chk("midrst_corr", cout[0], 0);
    repeat (10) @(negedge clk);
    chk("midrst_hold", cout[0], 0);
    set3(1, 2, 3, 1, 2, 4);
    run_pair(0, 3, 0);
    run_pair(0, 0, 1);
    set3(2, 0, 1, 3, 5, 7);
    run_pair(0, 0, 1);
    set3(1, 2, 3, 1, 2, 0);
    sa[3] = 4; sa[4] = 5;
    run_pair(1, 0, 0);
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < 5; i++) sa[i] = 16'($urandom);
      for (int i = 0; i < 3; i++) sb[i] = 16'($urandom);
      run_pair(r % 2, int'($urandom_range(0, 3)), 1'($urandom));
    end
    repeat (10) @(negedge clk);
    chk("drain3", q0.size(), 0);
    chk("drain5", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
